wx_rr_scheduler: RTL and testbench
==================================

// Module: wx_rr_scheduler
// PURPOSE
//  Shares one sequential W(x) evaluator, x^3+2x^2+x+1 with AXI-stream style slave/master ports,
//  between N_REQ requesters. Fair round-robin arbitration; one transaction in flight.
//  Accepts a sample, issues it to the engine, waits for the result, returns it to the owner.
//  A WAIT watchdog flags an engine that never answers. Sits between client blocks and the engine.
// PARAMETERS
//  N_REQ        4    number of requesters (>=2); IDX_W = $clog2(N_REQ) (localparam)
//  DATA_W       16   sample width x
//  RES_W        48   result width
//  TIMEOUT_CYC  32   max WAIT cycles before timeout (1..255; 8-bit timer)
// PORTS
//  in_clock      in   1             rising-edge clock
//  in_reset_n    in   1             async assert, active-low reset
//  req_tvalid    in   N_REQ         per-requester sample valid
//  req_tdata     in   N_REQ*DATA_W  requester i sample at [i*DATA_W +: DATA_W]
//  req_tready    out  N_REQ         one-hot accept to the winning requester
//  rsp_tvalid    out  N_REQ         one-hot result valid to the owning requester
//  rsp_tready    in   N_REQ         per-requester result ready
//  rsp_tdata     out  RES_W         result, shared bus, qualified by rsp_tvalid
//  eng_s_tvalid  out  1             sample valid to engine
//  eng_s_tdata   out  DATA_W        sample to engine
//  eng_s_tready  in   1             engine accepts a sample
//  eng_m_tvalid  in   1             engine result valid
//  eng_m_tdata   in   RES_W         engine result
//  eng_m_tready  out  1             scheduler ready for result
//  grant_id      out  IDX_W         owner of the current or last transaction
//  busy          out  1             state != IDLE
//  timeout_err   out  1             1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (in_reset_n=0, async): state=IDLE, all outputs 0, timer=0, data regs 0, last_grant=N_REQ-1.
//   Reset mid-transaction drops it silently; the requester re-presents after release.
//  FSM: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
//  IDLE: winner = first i with req_tvalid[i], scanning from (last_grant+1) mod N_REQ, wrapping.
//   req_tready[winner]=1, combinational, only in IDLE with any valid. On that edge: latch
//   sample, grant_id<=winner, last_grant<=winner, go ISSUE. Handshake = req_tvalid&req_tready.
//  ISSUE: eng_s_tvalid=1, eng_s_tdata=latched sample, stable until eng_s_tready=1; then WAIT, timer<=0.
//  WAIT: eng_m_tready=1 (only state where it is 1). eng_m_tvalid=1: latch eng_m_tdata, go RETURN.
//   Otherwise timer++. Timer reaching TIMEOUT_CYC-1 with no result: timeout_err=1 for one cycle,
//   result<= {RES_W{1'b1}}, go RETURN. Result valid and expiry in the same cycle: result wins, no error.
//  RETURN: rsp_tvalid[grant_id]=1, rsp_tdata=result, both stable under backpressure.
//   rsp_tready[grant_id]=1 -> IDLE next cycle. rsp_tready of other requesters is ignored.
//  Engine results outside WAIT are ignored (eng_m_tready=0) and never captured.
//  No new req_tready outside IDLE. Min turnaround: 1 idle cycle between RETURN and next accept.
//  Latency: accept @T -> eng_s_tvalid @T+1; eng_m handshake @E -> rsp_tvalid @E+1.
//  Data widths are passed through unchanged: no truncation, extension or arithmetic on samples/results.
//  Outputs other than req_tready are registered or decoded from state/registers only.
// TESTING
//  1 req0 x=0x0003; engine model returns 49 -> eng_s_tdata=0x0003, rsp_tvalid=0001, rsp_tdata=49, grant_id=0.
//  2 req1 x=0xFFFF -> rsp_tdata=48'hFFFF_0000_0001 exactly; rsp_tvalid=0010.
//  3 All 4 req_tvalid held high for 5 transactions -> grant order 0,1,2,3,0; req_tready always one-hot.
//  4 rsp_tready[2] low 5 cycles in RETURN -> rsp_tvalid/rsp_tdata stable, req_tready=0, busy=1.
//  5 Engine never asserts eng_m_tvalid -> timeout_err pulses after 32 WAIT cycles; rsp_tdata=all ones;
//    a late eng_m_tvalid pulse in IDLE is ignored.
//  6 in_reset_n low during WAIT -> all outputs 0 same cycle; after release req0 and req3 both valid -> req0 wins.

Source files
------------

// File: rtl/wx_rr_scheduler.sv
// Round-robin front end that lets N_REQ clients share one sequential W(x) engine.
// One transaction is in flight at a time. A watchdog substitutes an all-ones result if the engine stalls.
module wx_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 16,
    parameter int RES_W       = 48,
    parameter int TIMEOUT_CYC = 32,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                    in_clock,
    input  logic                    in_reset_n,
    input  logic [N_REQ-1:0]        req_tvalid,
    input  logic [N_REQ*DATA_W-1:0] req_tdata,
    output logic [N_REQ-1:0]        req_tready,
    output logic [N_REQ-1:0]        rsp_tvalid,
    input  logic [N_REQ-1:0]        rsp_tready,
    output logic [RES_W-1:0]        rsp_tdata,
    output logic                    eng_s_tvalid,
    output logic [DATA_W-1:0]       eng_s_tdata,
    input  logic                    eng_s_tready,
    input  logic                    eng_m_tvalid,
    input  logic [RES_W-1:0]        eng_m_tdata,
    output logic                    eng_m_tready,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_grant;
    logic [DATA_W-1:0]  r_sample;
    logic [RES_W-1:0]   r_result;
    logic [7:0]         r_timer;
    logic               r_timeout;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    int                 w_idx;
    logic [DATA_W-1:0]  w_req_data [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_req_data[gi] = req_tdata[gi*DATA_W +: DATA_W];
            // Accept is gated by reset so nothing is offered while the block is held in reset.
            assign req_tready[gi] = in_reset_n && (r_state == S_IDLE) && w_found
                                    && (w_winner == IDX_W'(gi));
            assign rsp_tvalid[gi] = (r_state == S_RETURN) && (r_grant == IDX_W'(gi));
        end
    endgenerate

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % N_REQ;
            if (!w_found && req_tvalid[IDX_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_next = S_ISSUE;
            S_ISSUE:  if (eng_s_tready) w_state_next = S_WAIT;
            S_WAIT:   if (eng_m_tvalid || (r_timer == TIMER_LAST)) w_state_next = S_RETURN;
            S_RETURN: if (rsp_tready[r_grant]) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_grant      <= '0;
            r_sample     <= '0;
            r_result     <= '0;
            r_timer      <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sample     <= w_req_data[w_winner];
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                S_ISSUE: begin
                    if (eng_s_tready) r_timer <= '0;
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle still wins over the watchdog.
                    if (eng_m_tvalid) begin
                        r_result <= eng_m_tdata;
                    end else if (r_timer == TIMER_LAST) begin
                        r_result  <= {RES_W{1'b1}};
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_s_tvalid = (r_state == S_ISSUE);
    assign eng_s_tdata  = r_sample;
    assign eng_m_tready = (r_state == S_WAIT);
    assign rsp_tdata    = r_result;
    assign grant_id     = r_grant;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_wx_rr_scheduler.sv
// Scoreboard bench for wx_rr_scheduler: directed requests push expected (owner, result) pairs,
// a monitor pops and compares them on every result handshake.
module tb_wx_rr_scheduler;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;
    localparam int RES_W  = 48;

    typedef struct {
        int               id;
        logic [RES_W-1:0] res;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_tvalid;
    logic [N_REQ*DATA_W-1:0] req_tdata;
    logic [N_REQ-1:0]        req_tready;
    logic [N_REQ-1:0]        rsp_tvalid;
    logic [N_REQ-1:0]        rsp_tready;
    logic [RES_W-1:0]        rsp_tdata;
    logic                    eng_s_tvalid;
    logic [DATA_W-1:0]       eng_s_tdata;
    logic                    eng_s_tready;
    logic                    eng_m_tvalid;
    logic [RES_W-1:0]        eng_m_tdata;
    logic                    eng_m_tready;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    timeout_err;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // engine model controls
    int   eng_lat = 2;
    int   s_delay = 1;
    bit   eng_mute = 1'b0;
    int   late_seq = 0;
    logic [DATA_W-1:0] last_sample = '0;

    // monitor outputs
    int acc_cnt = 0;
    int last_acc_id = -1;
    int to_cnt = 0;
    int to_wait = 0;

    always #5 clk = ~clk;

    wx_rr_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYC(32)) dut (
        .in_clock     (clk),
        .in_reset_n   (rst_n),
        .req_tvalid   (req_tvalid),
        .req_tdata    (req_tdata),
        .req_tready   (req_tready),
        .rsp_tvalid   (rsp_tvalid),
        .rsp_tready   (rsp_tready),
        .rsp_tdata    (rsp_tdata),
        .eng_s_tvalid (eng_s_tvalid),
        .eng_s_tdata  (eng_s_tdata),
        .eng_s_tready (eng_s_tready),
        .eng_m_tvalid (eng_m_tvalid),
        .eng_m_tdata  (eng_m_tdata),
        .eng_m_tready (eng_m_tready),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [RES_W-1:0] wx(input logic [DATA_W-1:0] x);
        logic [RES_W-1:0] xx;
        xx = RES_W'(x);
        return xx * xx * xx + 2 * xx * xx + xx + 1;
    endfunction

    // Engine: accepts a sample after s_delay cycles, answers eng_lat cycles later (unless muted).
    initial begin
        logic             s_fire, m_fire, e_busy, pulse_on;
        logic [DATA_W-1:0] x_cap;
        int               e_cnt, s_cnt, late_done;
        eng_s_tready = 1'b0; eng_m_tvalid = 1'b0; eng_m_tdata = '0;
        e_busy = 1'b0; pulse_on = 1'b0; e_cnt = 0; s_cnt = 0; late_done = 0; x_cap = '0;
        forever begin
            @(negedge clk);
            s_fire = rst_n && eng_s_tvalid && eng_s_tready;
            m_fire = rst_n && eng_m_tvalid && eng_m_tready;
            if (s_fire) x_cap = eng_s_tdata;
            @(posedge clk); #1;
            if (!rst_n) begin
                eng_s_tready = 1'b0; eng_m_tvalid = 1'b0; e_busy = 1'b0; s_cnt = 0; pulse_on = 1'b0;
            end else if (pulse_on) begin
                eng_m_tvalid = 1'b0; pulse_on = 1'b0;
            end else if (late_done != late_seq) begin
                late_done = late_seq; eng_m_tvalid = 1'b1; eng_m_tdata = 48'h0000_0000_ABCD; pulse_on = 1'b1;
            end else begin
                if (m_fire) eng_m_tvalid = 1'b0;
                if (s_fire) begin
                    eng_s_tready = 1'b0; s_cnt = 0; e_busy = 1'b1; e_cnt = eng_lat; last_sample = x_cap;
                end else if (e_busy) begin
                    if (e_cnt == 0) begin
                        e_busy = 1'b0;
                        if (!eng_mute) begin eng_m_tvalid = 1'b1; eng_m_tdata = wx(x_cap); end
                    end else e_cnt--;
                end else if (eng_s_tvalid && !eng_m_tvalid) begin
                    if (s_cnt >= s_delay) eng_s_tready = 1'b1;
                    else s_cnt++;
                end
            end
        end
    end

    // Monitor: accept bookkeeping, result scoreboard, watchdog timing.
    initial begin
        int wait_run;
        exp_t e;
        wait_run = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_tready != '0) begin
                    check("req_tready_onehot", 64'($onehot(req_tready)), 64'd1);
                    check("req_tready_only_idle", 64'(busy), 64'd0);
                end
                for (int i = 0; i < N_REQ; i++)
                    if (req_tvalid[i] && req_tready[i]) begin acc_cnt++; last_acc_id = i; end
                if ((rsp_tvalid & rsp_tready) != '0) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_tvalid), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_tvalid", 64'(rsp_tvalid), 64'd1 << e.id);
                        check("rsp_tdata", 64'(rsp_tdata), 64'(e.res));
                        check("grant_id", 64'(grant_id), 64'(e.id));
                        $display("rsp: owner=%0d data=0x%0h", e.id, rsp_tdata);
                    end
                end
                if (eng_m_tready) wait_run++;
                else begin
                    if (timeout_err) begin to_cnt++; to_wait = wait_run; end
                    wait_run = 0;
                end
            end else wait_run = 0;
        end
    end

    task automatic wait_accept(input int base);
        int c = 0;
        while (acc_cnt == base && c < 200) begin @(posedge clk); #1; c++; end
        check("accept_seen", 64'(acc_cnt - base), 64'd1);
    endtask

    task automatic send(input int id, input logic [DATA_W-1:0] x, input logic [RES_W-1:0] exp);
        int base;
        sb_q.push_back('{id, exp});
        base = acc_cnt;
        req_tdata[id*DATA_W +: DATA_W] = x;
        req_tvalid[id] = 1'b1;
        wait_accept(base);
        req_tvalid[id] = 1'b0;
        check("issue_latency", 64'(eng_s_tvalid), 64'd1);
        $display("req: id=%0d x=0x%0h", id, x);
    endtask

    task automatic wait_done();
        int c = 0;
        while ((sb_q.size() != 0 || busy) && c < 300) begin @(posedge clk); #1; c++; end
        check("drain_queue", 64'(sb_q.size()), 64'd0);
        check("drain_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_req_tready"}, 64'(req_tready), 64'd0);
        check({tag, "_rsp_tvalid"}, 64'(rsp_tvalid), 64'd0);
        check({tag, "_rsp_tdata"}, 64'(rsp_tdata), 64'd0);
        check({tag, "_eng_s_tvalid"}, 64'(eng_s_tvalid), 64'd0);
        check({tag, "_eng_s_tdata"}, 64'(eng_s_tdata), 64'd0);
        check({tag, "_eng_m_tready"}, 64'(eng_m_tready), 64'd0);
        check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int base, c;
        rst_n = 1'b0; req_tvalid = '0; req_tdata = '0; rsp_tready = '1;

        // Reset state, with a request already waiting that must not be acknowledged.
        req_tvalid = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        req_tvalid = '0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1: req0 x=3 -> 49
        send(0, 16'h0003, 48'd49);
        wait_done();
        check("t1_eng_s_tdata", 64'(last_sample), 64'h3);

        // 2: req1 x=0xFFFF -> exact 48-bit result
        send(1, 16'hFFFF, 48'hFFFF_0000_0001);
        wait_done();
        check("t2_eng_s_tdata", 64'(last_sample), 64'hFFFF);

        // req3 x=4 -> 101, leaves last grant at 3
        send(3, 16'h0004, 48'd101);
        wait_done();

        // 3: all requesters held valid for 5 accepts -> 0,1,2,3,0
        s_delay = 0;
        for (int i = 0; i < N_REQ; i++) req_tdata[i*DATA_W +: DATA_W] = 16'(i + 1);
        sb_q.push_back('{0, 48'd5});
        sb_q.push_back('{1, 48'd19});
        sb_q.push_back('{2, 48'd49});
        sb_q.push_back('{3, 48'd101});
        sb_q.push_back('{0, 48'd5});
        base = acc_cnt;
        req_tvalid = 4'b1111;
        c = 0;
        while (acc_cnt < base + 5 && c < 500) begin @(posedge clk); #1; c++; end
        req_tvalid = '0;
        check("t3_accepts", 64'(acc_cnt - base), 64'd5);
        wait_done();

        // 4: backpressure on req2, other readies high, req0 waiting meanwhile
        rsp_tready = 4'b1011;
        send(2, 16'h0002, 48'd19);
        req_tdata[0 +: DATA_W] = 16'h0001;
        req_tvalid[0] = 1'b1;
        sb_q.push_back('{0, 48'd5});
        c = 0;
        do begin @(negedge clk); c++; end while (!rsp_tvalid[2] && c < 100);
        for (int k = 0; k < 5; k++) begin
            check("t4_rsp_tvalid_hold", 64'(rsp_tvalid), 64'b0100);
            check("t4_rsp_tdata_hold", 64'(rsp_tdata), 64'd19);
            check("t4_req_tready", 64'(req_tready), 64'd0);
            check("t4_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        base = acc_cnt;
        @(posedge clk); #1;
        rsp_tready = '1;
        wait_accept(base);
        req_tvalid[0] = 1'b0;
        check("t4_second_owner", 64'(last_acc_id), 64'd0);
        wait_done();

        // 5: silent engine -> watchdog, then a stray result pulse in IDLE is ignored
        eng_mute = 1'b1;
        send(1, 16'h0007, {RES_W{1'b1}});
        wait_done();
        check("t5_timeout_pulses", 64'(to_cnt), 64'd1);
        check("t5_wait_cycles", 64'(to_wait), 64'd32);
        eng_mute = 1'b0;
        late_seq++;
        repeat (3) begin
            @(negedge clk);
            check("t5_late_busy", 64'(busy), 64'd0);
            check("t5_late_m_tready", 64'(eng_m_tready), 64'd0);
        end
        check("t5_result_kept", 64'(rsp_tdata), 64'hFFFF_FFFF_FFFF);
        check("t5_no_extra_timeout", 64'(to_cnt), 64'd1);

        // 6: reset during WAIT, then req0 beats req3
        s_delay = 1;
        eng_lat = 20;
        send(2, 16'h0001, 48'd5);
        c = 0;
        while (!eng_m_tready && c < 50) begin @(posedge clk); #1; c++; end
        check("t6_in_wait", 64'(eng_m_tready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_all_zero("t6_reset");
        req_tdata[0 +: DATA_W] = 16'h0003;
        req_tdata[3*DATA_W +: DATA_W] = 16'h0004;
        req_tvalid = 4'b1001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_reset_req_tready", 64'(req_tready), 64'd0);
        eng_lat = 2;
        sb_q.push_back('{0, 48'd49});
        base = acc_cnt;
        @(posedge clk); #3;
        rst_n = 1'b1;
        wait_accept(base);
        req_tvalid = '0;
        check("t6_winner", 64'(last_acc_id), 64'd0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
